mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mem_arbiter: two-master round-robin arbiter for one synchronous SRAM port,  |
// | with locked bursts bounded by MAX_BURST while the other master waits.       |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif

module mem_arbiter #(
  parameter int MAX_BURST = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req_i,
  input  logic             m0_lock_i,
  input  logic             m0_we_i,
  input  logic [`ADDR_BUS] m0_addr_i,
  input  logic [3:0]       m0_width_i,
  input  logic [`DATA_BUS] m0_data_i,
  output logic             m0_gnt_o,
  output logic             m0_ack_o,
  output logic [`DATA_BUS] m0_data_o,
  input  logic             m1_req_i,
  input  logic             m1_lock_i,
  input  logic             m1_we_i,
  input  logic [`ADDR_BUS] m1_addr_i,
  input  logic [3:0]       m1_width_i,
  input  logic [`DATA_BUS] m1_data_i,
  output logic             m1_gnt_o,
  output logic             m1_ack_o,
  output logic [`DATA_BUS] m1_data_o,
  output logic             mem_ce_o,
  output logic             mem_we_o,
  output logic [`ADDR_BUS] mem_addr_o,
  output logic [3:0]       mem_width_o,
  output logic [`DATA_BUS] mem_data_o,
  input  logic [`DATA_BUS] mem_data_i
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             owner;
  logic             prio;
  logic             acc_we;
  logic [CNT_W-1:0] burst_cnt;

  logic             own_req;
  logic             own_lock;
  logic             own_we;
  logic [`ADDR_BUS] own_addr;
  logic [3:0]       own_width;
  logic [`DATA_BUS] own_data;
  logic             oth_req;

  always_comb begin
    own_req   = owner ? m1_req_i   : m0_req_i;
    own_lock  = owner ? m1_lock_i  : m0_lock_i;
    own_we    = owner ? m1_we_i    : m0_we_i;
    own_addr  = owner ? m1_addr_i  : m0_addr_i;
    own_width = owner ? m1_width_i : m0_width_i;
    own_data  = owner ? m1_data_i  : m0_data_i;
    oth_req   = owner ? m0_req_i   : m1_req_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      prio      <= 1'b0;
      acc_we    <= 1'b0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req_i || m1_req_i) begin
            owner     <= (m0_req_i && m1_req_i) ? prio : m1_req_i;
            burst_cnt <= '0;
            state     <= ACC;
          end
        end
        ACC: begin
          // Remember the access direction so read data can be suppressed on write acks.
          acc_we <= own_we;
          if (!oth_req) burst_cnt <= '0;
          state <= RESP;
        end
        RESP: begin
          if (oth_req && (burst_cnt == BURST_LAST)) begin
            state     <= IDLE;
            prio      <= ~owner;
            burst_cnt <= '0;
          end else if (own_req && own_lock) begin
            state     <= ACC;
            burst_cnt <= oth_req ? (burst_cnt + CNT_W'(1)) : '0;
          end else begin
            state     <= IDLE;
            prio      <= ~owner;
            burst_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic             in_acc;
  logic             in_resp;
  logic             busy;
  logic [`DATA_BUS] resp_data;

  // Outputs are decoded from registered state and held at zero while reset is asserted.
  always_comb begin
    in_acc      = !rst && (state == ACC);
    in_resp     = !rst && (state == RESP);
    busy        = !rst && (state != IDLE);
    resp_data   = acc_we ? '0 : mem_data_i;
    m0_gnt_o    = busy && !owner;
    m1_gnt_o    = busy && owner;
    m0_ack_o    = in_resp && !owner;
    m1_ack_o    = in_resp && owner;
    m0_data_o   = m0_ack_o ? resp_data : '0;
    m1_data_o   = m1_ack_o ? resp_data : '0;
    mem_ce_o    = in_acc;
    mem_we_o    = in_acc && own_we;
    mem_addr_o  = in_acc ? own_addr  : '0;
    mem_width_o = in_acc ? own_width : '0;
    mem_data_o  = in_acc ? own_data  : '0;
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_mem_arbiter: self-checking bench for mem_arbiter with an SRAM model and  |
// | a transaction-level shadow memory.  Revision: 1.0                           |
// +-----------------------------------------------------------------------------+
`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif

module tb_mem_arbiter;

  localparam int MAX_BURST = 16;

  logic        clk;
  logic        rst;
  logic        req [2];
  logic        lock[2];
  logic        we  [2];
  logic [31:0] addr[2];
  logic [3:0]  width[2];
  logic [31:0] wdat[2];
  logic        gnt [2];
  logic        ack [2];
  logic [31:0] dout[2];
  logic        mem_ce, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_width;

  int total = 0;
  int bad   = 0;

  logic [31:0] sram  [0:255];
  logic [31:0] shadow[0:255];

  mem_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(req[0]), .m0_lock_i(lock[0]), .m0_we_i(we[0]), .m0_addr_i(addr[0]),
    .m0_width_i(width[0]), .m0_data_i(wdat[0]),
    .m0_gnt_o(gnt[0]), .m0_ack_o(ack[0]), .m0_data_o(dout[0]),
    .m1_req_i(req[1]), .m1_lock_i(lock[1]), .m1_we_i(we[1]), .m1_addr_i(addr[1]),
    .m1_width_i(width[1]), .m1_data_i(wdat[1]),
    .m1_gnt_o(gnt[1]), .m1_ack_o(ack[1]), .m1_data_o(dout[1]),
    .mem_ce_o(mem_ce), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_width_o(mem_width), .mem_data_o(mem_wdata), .mem_data_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM: read data appears the cycle after the chip-enable cycle.
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) sram[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr[9:2]];
    end
  end

  logic any_out;
  assign any_out = gnt[0] | gnt[1] | ack[0] | ack[1] | (|dout[0]) | (|dout[1]) |
                   mem_ce | mem_we | (|mem_addr) | (|mem_width) | (|mem_wdata);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle invariants plus the starvation bound, sampled after the drivers settle.
  int consec[2] = '{0, 0};
  always @(negedge clk) begin
    #2;
    chk("gnt_onehot", {31'd0, gnt[0] & gnt[1]}, 32'd0);
    chk("ack_owner", {31'd0, (ack[0] & !gnt[0]) | (ack[1] & !gnt[1])}, 32'd0);
    chk("ce_granted", {31'd0, mem_ce & !(gnt[0] | gnt[1])}, 32'd0);
    chk("bus_quiet", {31'd0, !mem_ce && (mem_we || mem_addr != 0 || mem_width != 0 || mem_wdata != 0)}, 32'd0);
    chk("data_quiet", {31'd0, (!ack[0] && dout[0] != 0) || (!ack[1] && dout[1] != 0)}, 32'd0);
    if (mem_ce) begin
      chk("mux_addr",  mem_addr,  gnt[1] ? addr[1]  : addr[0]);
      chk("mux_width", {28'd0, mem_width}, {28'd0, gnt[1] ? width[1] : width[0]});
    end
    for (int i = 0; i < 2; i++) begin
      if (rst || !req[1-i] || ack[1-i]) consec[i] = 0;
      else if (ack[i]) begin
        consec[i]++;
        chk("burst_guard", {31'd0, consec[i] > MAX_BURST}, 32'd0);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic access(input int m, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int lat, output int ce);
    req[m] = 1'b1; lock[m] = 1'b0; we[m] = w; addr[m] = a; wdat[m] = d; width[m] = 4'd4;
    lat = 0; ce = 0; rd = '0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (mem_ce && gnt[m]) ce++;
      if (ack[m]) begin
        rd = dout[m];
        if (w) shadow[a[9:2]] = d;
        break;
      end
    end
    req[m] = 1'b0; we[m] = 1'b0;
  endtask

  task automatic driver(input int m, input int ntx);
    int waited;
    logic [31:0] a;
    @(negedge clk);
    for (int n = 0; n < ntx; n++) begin
      if (!req[m]) repeat ($urandom_range(0, 3)) @(negedge clk);
      a        = 32'($urandom_range(0, 15)) << 2;
      we[m]    = 1'($urandom_range(0, 1));
      addr[m]  = a;
      wdat[m]  = $urandom;
      width[m] = 4'($urandom_range(0, 15));
      lock[m]  = ($urandom_range(0, 2) != 0);
      req[m]   = 1'b1;
      waited   = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!ack[m] && waited < 400);
      chk("rnd_acked", {31'd0, ack[m]}, 32'd1);
      if (!ack[m]) begin
        req[m] = 1'b0; lock[m] = 1'b0;
        return;
      end
      if (we[m]) begin
        chk("rnd_wr_data", dout[m], 32'd0);
        shadow[a[9:2]] = wdat[m];
      end else begin
        chk("rnd_rd_data", dout[m], shadow[a[9:2]]);
      end
      if (n == ntx - 1 || $urandom_range(0, 3) == 0) begin
        req[m] = 1'b0; lock[m] = 1'b0;
      end
    end
    req[m] = 1'b0; lock[m] = 1'b0;
  endtask

  typedef struct {
    int          m;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t        vecs[8];
    logic [31:0] rd;
    logic [31:0] bdata[4];
    int          lat, ce, cyc, nack, gaps, first, n1, last1, g0;
    int          order[2];
    logic        got0;

    for (int i = 0; i < 256; i++) begin
      sram[i]   = 32'h1000_0000 + 32'(i);
      shadow[i] = 32'h1000_0000 + 32'(i);
    end
    sram[16] = 32'hDEAD_BEEF; shadow[16] = 32'hDEAD_BEEF;
    mem_rdata = '0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 0; lock[i] = 0; we[i] = 0; addr[i] = 0; width[i] = 0; wdat[i] = 0;
    end

    vecs[0] = '{0, 1'b0, 32'd64,   32'd0,         32'hDEAD_BEEF};
    vecs[1] = '{1, 1'b1, 32'd200,  32'h1234_5678, 32'd0};
    vecs[2] = '{0, 1'b0, 32'd200,  32'd0,         32'h1234_5678};
    vecs[3] = '{0, 1'b1, 32'd0,    32'hA5A5_A5A5, 32'd0};
    vecs[4] = '{1, 1'b0, 32'd0,    32'd0,         32'hA5A5_A5A5};
    vecs[5] = '{1, 1'b0, 32'd1020, 32'd0,         32'h1000_00FF};
    vecs[6] = '{0, 1'b1, 32'd1020, 32'hFFFF_FFFF, 32'd0};
    vecs[7] = '{0, 1'b0, 32'd1020, 32'd0,         32'hFFFF_FFFF};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {31'd0, any_out}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", {31'd0, any_out}, 32'd0);

    // Two back-to-back ties after reset: master 0 first both times
    for (int t = 0; t < 2; t++) begin
      req[0] = 1; we[0] = 0; addr[0] = 32'd64; width[0] = 4'd4;
      req[1] = 1; we[1] = 0; addr[1] = 32'd4;  width[1] = 4'd4;
      cyc = 0; nack = 0; order[0] = -1; order[1] = -1; first = 0;
      while (nack < 2 && cyc < 30) begin
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) if (ack[i]) begin
          order[nack] = i;
          if (i == 0) chk("tie_m0_data", dout[0], 32'hDEAD_BEEF);
          else begin
            chk("tie_m1_data", dout[1], 32'h1000_0001);
            first = cyc;
          end
          nack++;
          req[i] = 0;
        end
      end
      chk("tie_first",  order[0], 32'd0);
      chk("tie_second", order[1], 32'd1);
      chk("tie_m1_cycle", first, 32'd5);
      @(negedge clk);
    end

    // Table of single accesses, other master idle
    foreach (vecs[k]) begin
      access(vecs[k].m, vecs[k].w, vecs[k].a, vecs[k].d, rd, lat, ce);
      chk("vec_latency", lat, 32'd2);
      chk("vec_ce_cycles", ce, 32'd1);
      chk("vec_data", rd, vecs[k].exp);
      @(negedge clk);
    end

    // Locked burst of four writes by master 1
    for (int k = 0; k < 4; k++) bdata[k] = $urandom;
    lock[1] = 1; we[1] = 1; width[1] = 4'd4; addr[1] = 32'd128; wdat[1] = bdata[0]; req[1] = 1;
    cyc = 0; nack = 0; gaps = 0;
    while (nack < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!gnt[1]) gaps++;
      if (ack[1]) begin
        chk("burst_ack_time", cyc, 32'(2 * (nack + 1)));
        shadow[addr[1][9:2]] = wdat[1];
        nack++;
        if (nack < 4) begin
          addr[1] = 32'd128 + 32'(4 * nack); wdat[1] = bdata[nack];
        end else begin
          req[1] = 0; lock[1] = 0; we[1] = 0;
        end
      end
    end
    chk("burst_acks", nack, 32'd4);
    chk("burst_no_idle", gaps, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      access(0, 1'b0, 32'd128 + 32'(4 * k), 32'd0, rd, lat, ce);
      chk("burst_readback", rd, bdata[k]);
    end

    // Starvation guard: m1 locked forever, m0 waiting from m1's first ACC
    @(negedge clk);
    lock[1] = 1; we[1] = 1; width[1] = 4'd4; addr[1] = 32'd256; wdat[1] = $urandom; req[1] = 1;
    cyc = 0; n1 = 0; last1 = -1; g0 = -1; got0 = 0; rd = '0;
    while (!got0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        req[0] = 1; lock[0] = 0; we[0] = 0; addr[0] = 32'd64; width[0] = 4'd4;
      end
      if (ack[1]) begin
        shadow[addr[1][9:2]] = wdat[1];
        n1++; last1 = cyc;
        addr[1] = 32'd256 + 32'(4 * (n1 % 8)); wdat[1] = $urandom;
      end
      if (gnt[0] && g0 < 0) g0 = cyc;
      if (ack[0]) begin
        got0 = 1; rd = dout[0];
        req[0] = 0; req[1] = 0; lock[1] = 0; we[1] = 0;
      end
    end
    chk("starve_m1_acks", n1, 32'd16);
    chk("starve_m0_served", {31'd0, got0}, 32'd1);
    chk("starve_grant_gap", {31'd0, (g0 - last1) <= 2 && g0 > last1}, 32'd1);
    chk("starve_m0_data", rd, 32'hDEAD_BEEF);

    // Reset in the middle of an access
    @(negedge clk);
    req[0] = 1; we[0] = 0; addr[0] = 32'd64; width[0] = 4'd4;
    @(negedge clk);
    chk("rst_mid_ce", {31'd0, mem_ce}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_outs", {31'd0, any_out}, 32'd0);
    @(negedge clk);
    chk("rst_mid_next", {31'd0, any_out}, 32'd0);
    req[0] = 0;
    @(negedge clk);
    chk("rst_mid_noack", {31'd0, ack[0] | ack[1]}, 32'd0);
    rst = 1'b0;
    access(0, 1'b0, 32'd64, 32'd0, rd, lat, ce);
    chk("rst_recover_lat", lat, 32'd2);
    chk("rst_recover_data", rd, 32'hDEAD_BEEF);

    // Randomized traffic from both masters against the shadow memory
    fork
      driver(0, 60);
      driver(1, 60);
    join
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
